// File: rtl/tick_timer_sched_pkg.sv
// Shared defaults and types for the millisecond timer scheduler.
// TICK_HZ records the divider rate that makes one tick equal one millisecond.
package tick_timer_sched_pkg;

  localparam int unsigned N_CH_DEF  = 4;
  localparam int unsigned CNT_W_DEF = 16;
  localparam int unsigned TICK_HZ   = 1000;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_state_e;

  // Pointer width for an N-entry round robin, never narrower than one bit.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_timer_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after the pointer.
// The pointer moves past the granted index only when advance is high.
module rr_arbiter
  import tick_timer_sched_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int unsigned PW = ptr_width(N);

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] gidx;
  logic [PW-1:0] idx_p;
  logic          found;
  int unsigned   idx;

  always_comb begin
    gnt   = '0;
    gidx  = '0;
    idx   = 0;
    idx_p = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      idx   = (32'(ptr_q) + k) % N;
      idx_p = PW'(idx);
      if (!found && req[idx_p]) begin
        found      = 1'b1;
        gnt[idx_p] = 1'b1;
        gidx       = idx_p;
      end
    end
    if (rst) begin
      gnt   = '0;
      found = 1'b0;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance && found) begin
      ptr_d = (32'(gidx) == N - 1) ? '0 : gidx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/tick_timer_sched.sv
// N_CH millisecond countdown timers sharing one 1 kHz tick; arms are
// accepted one per clock through a round-robin valid/ready handshake.
module tick_timer_sched
  import tick_timer_sched_pkg::*;
#(
  parameter int unsigned N_CH  = N_CH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_tick,
  input  logic [N_CH-1:0]       req_valid,
  input  logic [N_CH*CNT_W-1:0] req_ms,
  output logic [N_CH-1:0]       req_ready,
  input  logic [N_CH-1:0]       cancel,
  output logic [N_CH-1:0]       o_busy,
  output logic [N_CH-1:0]       o_done
);

  logic [N_CH-1:0] eligible;
  logic [N_CH-1:0] accept;
  logic            accept_any;

  // A cancelled channel must never be granted in the same cycle.
  assign eligible   = req_valid & ~cancel;
  assign accept     = req_valid & req_ready;
  assign accept_any = |accept;

  rr_arbiter #(
    .N(N_CH)
  ) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (eligible),
    .advance(accept_any),
    .gnt    (req_ready)
  );

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    ch_state_e        st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] ms;
    logic             done_q, done_d;

    assign ms = req_ms[i*CNT_W +: CNT_W];

    // Priority: cancel, then arm, then tick decrement.
    always_comb begin
      st_d   = st_q;
      cnt_d  = cnt_q;
      done_d = 1'b0;
      if (cancel[i]) begin
        st_d  = CH_IDLE;
        cnt_d = '0;
      end else if (accept[i]) begin
        if (ms == '0) begin
          st_d   = CH_IDLE;
          cnt_d  = '0;
          done_d = 1'b1;
        end else begin
          st_d  = CH_RUN;
          cnt_d = ms;
        end
      end else if (st_q == CH_RUN && i_tick) begin
        if (cnt_q == CNT_W'(1)) begin
          st_d   = CH_IDLE;
          cnt_d  = '0;
          done_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        st_q   <= CH_IDLE;
        cnt_q  <= '0;
        done_q <= 1'b0;
      end else begin
        st_q   <= st_d;
        cnt_q  <= cnt_d;
        done_q <= done_d;
      end
    end

    assign o_busy[i] = (st_q == CH_RUN);
    assign o_done[i] = done_q;
  end

endmodule

// File: tb/tb_tick_timer_sched.sv
// Bench for tick_timer_sched: directed scenarios plus random traffic,
// all checked cycle by cycle against a remaining-milliseconds model.
module tb_tick_timer_sched;

  localparam int N        = 4;
  localparam int W        = 16;
  localparam int TICK_DIV = 10;

  logic           clk = 1'b0;
  logic           rst;
  logic           i_tick;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_ms;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   cancel;
  logic [N-1:0]   o_busy;
  logic [N-1:0]   o_done;

  always #5 clk = ~clk;

  tick_timer_sched #(
    .N_CH (N),
    .CNT_W(W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_tick   (i_tick),
    .req_valid(req_valid),
    .req_ms   (req_ms),
    .req_ready(req_ready),
    .cancel   (cancel),
    .o_busy   (o_busy),
    .o_done   (o_done)
  );

  int           n_total = 0;
  int           n_bad   = 0;
  int           tcnt    = 0;
  logic [N-1:0] last_ready;

  // Reference: per-channel remaining milliseconds and pending expiry pulse.
  bit m_busy[N];
  int m_rem[N];
  bit m_done[N];
  int m_ptr;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] pack_busy();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_busy[i];
    return v;
  endfunction

  function automatic logic [N-1:0] pack_done();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_done[i];
    return v;
  endfunction

  function automatic logic [N-1:0] model_grant();
    logic [N-1:0] g;
    g = '0;
    if (rst) return g;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (req_valid[idx] && !cancel[idx]) begin
        g[idx] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  task automatic model_step(input logic [N-1:0] g);
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_busy[i] = 0;
        m_rem[i]  = 0;
        m_done[i] = 0;
      end
      m_ptr = 0;
      return;
    end
    for (int i = 0; i < N; i++) begin
      m_done[i] = 0;
      if (cancel[i]) begin
        m_busy[i] = 0;
      end else if (g[i]) begin
        int d;
        d = int'(req_ms[i*W +: W]);
        if (d == 0) begin
          m_busy[i] = 0;
          m_done[i] = 1;
        end else begin
          m_busy[i] = 1;
          m_rem[i]  = d;
        end
      end else if (m_busy[i] && i_tick) begin
        m_rem[i] = m_rem[i] - 1;
        if (m_rem[i] == 0) begin
          m_busy[i] = 0;
          m_done[i] = 1;
        end
      end
    end
    for (int i = 0; i < N; i++) if (g[i]) m_ptr = (i + 1) % N;
  endtask

  // One clock: tick from the divider emulation, check, advance model,
  // requesters drop accepted requests, cancel/rst pulses end.
  task automatic cycle();
    logic [N-1:0] g;
    i_tick = (tcnt == TICK_DIV - 1);
    @(negedge clk);
    g          = model_grant();
    last_ready = req_ready;
    check_eq("ready", req_ready, g);
    check_eq("busy", o_busy, pack_busy());
    check_eq("done", o_done, pack_done());
    model_step(g);
    @(posedge clk);
    #1;
    tcnt      = (tcnt + 1) % TICK_DIV;
    req_valid = req_valid & ~last_ready;
    cancel    = '0;
    rst       = 1'b0;
  endtask

  task automatic arm(input int ch, input int ms);
    req_valid[ch]        = 1'b1;
    req_ms[ch*W +: W]    = W'(ms);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
  endtask

  // Run until n_ticks more ticks have been applied plus one cycle; report
  // done pulses on ch and the tick count at the first one.
  task automatic watch(input int ch, input int n_ticks, output int dones, output int first);
    int ticks;
    int extra;
    ticks = 0;
    extra = 0;
    dones = 0;
    first = -1;
    for (int c = 0; c < (n_ticks + 1) * TICK_DIV + 2; c++) begin
      cycle();
      if (i_tick) ticks++;
      if (o_done[ch]) begin
        dones++;
        if (first < 0) first = ticks;
      end
      if (ticks == n_ticks) extra++;
      if (extra == 2) break;
    end
  endtask

  initial begin
    int d, f;
    rst       = 1'b1;
    i_tick    = 1'b0;
    req_valid = '0;
    req_ms    = '0;
    cancel    = '0;
    for (int i = 0; i < N; i++) begin
      m_busy[i] = 0;
      m_rem[i]  = 0;
      m_done[i] = 0;
    end
    m_ptr = 0;
    @(posedge clk);
    #1;
    check_eq("rst_busy", o_busy, 0);
    check_eq("rst_done", o_done, 0);

    // Ready must stay low while reset is asserted
    req_valid = 4'b0101;
    do_reset();
    check_eq("rst_ready", last_ready, 0);
    req_valid = '0;

    // Basic 3 ms timer on ch0
    arm(0, 3);
    cycle();
    check_eq("t1_ready", last_ready, 4'b0001);
    check_eq("t1_busy", o_busy[0], 1);
    watch(0, 3, d, f);
    check_eq("t1_ndone", d, 1);
    check_eq("t1_tick", f, 3);
    check_eq("t1_idle", o_busy[0], 0);

    // Round-robin order from pointer 0
    do_reset();
    for (int i = 0; i < N; i++) arm(i, 5);
    for (int c = 0; c < N; c++) begin
      cycle();
      check_eq("rr_order", last_ready, 32'(1) << c);
    end
    arm(2, 5);
    cycle();
    check_eq("rr_alone", last_ready, 4'b0100);

    // Zero-length timer
    do_reset();
    arm(1, 0);
    cycle();
    check_eq("z_ready", last_ready[1], 1);
    check_eq("z_busy", o_busy[1], 0);
    check_eq("z_done", o_done[1], 1);
    cycle();
    check_eq("z_once", o_done[1], 0);

    // Cancel mid-count, with a coincident request
    do_reset();
    arm(3, 10);
    cycle();
    watch(3, 4, d, f);
    check_eq("c_early", d, 0);
    arm(3, 10);
    cancel[3] = 1'b1;
    cycle();
    check_eq("c_ready", last_ready[3], 0);
    check_eq("c_busy", o_busy[3], 0);
    req_valid[3] = 1'b0;
    watch(3, 20, d, f);
    check_eq("c_nodone", d, 0);

    // Re-arm restarts; arm on a tick is not decremented
    do_reset();
    arm(2, 5);
    cycle();
    watch(2, 3, d, f);
    check_eq("ra_early", d, 0);
    arm(2, 2);
    cycle();
    watch(2, 4, d, f);
    check_eq("ra_ndone", d, 1);
    check_eq("ra_tick", f, 2);
    for (int c = 0; c < TICK_DIV && tcnt != TICK_DIV - 1; c++) cycle();
    arm(2, 2);
    cycle();
    check_eq("tk_armtick", i_tick, 1);
    watch(2, 3, d, f);
    check_eq("tk_ndone", d, 1);
    check_eq("tk_tick", f, 2);

    // Reset mid-count drops timers and rewinds the pointer
    do_reset();
    arm(0, 8);
    arm(1, 8);
    cycle();
    cycle();
    watch(0, 2, d, f);
    rst = 1'b1;
    cycle();
    check_eq("mr_busy", o_busy, 0);
    check_eq("mr_done", o_done, 0);
    watch(0, 10, d, f);
    check_eq("mr_nodone", d, 0);
    req_valid = 4'b1010;
    req_ms    = {4{16'd3}};
    cycle();
    check_eq("mr_ptr", last_ready, 4'b0010);
    req_valid = '0;

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && ($urandom % 8 == 0)) begin
          if ($urandom % 4 == 0) arm(i, 0);
          else if ($urandom % 5 == 0) arm(i, int'($urandom_range(7, 40)));
          else arm(i, int'($urandom_range(1, 6)));
        end
        cancel[i] = ($urandom % 24 == 0);
      end
      rst = ($urandom % 400 == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
